nn_mac_neuron_pe: RTL and testbench
===================================

Name: nn_mac_neuron_pe

Overview:
- Single-neuron processing element inside tt_um_nn_accelerator, directly upstream of the uo_out output path.
- Accepts a stream of signed 8-bit activation/weight pairs and accumulates their dot product onto a bias.
- After the programmed vector length, applies arithmetic right-shift requantization, optional ReLU and signed 8-bit saturation.
- Holds the result for the top level to drive onto uo_out.

Parameters:
- DATA_W, 8, activation/weight/bias/output width (signed two's complement).
- ACC_W, 20, accumulator width; sized so MAX_LEN products plus bias never wrap.
- MAX_LEN, 16, maximum vector length.
- LEN_W, 5, width of vec_len (0..MAX_LEN).
- SHIFT_W, 3, width of the requantization shift.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  global enable; when low all state is frozen
- start  in  1  single-cycle pulse: latch config, begin a new vector
- vec_len  in  LEN_W  number of pairs, 0..16, sampled on start
- bias  in  DATA_W  signed bias, sampled on start
- shift  in  SHIFT_W  arithmetic right shift, sampled on start
- relu_en  in  1  enable ReLU, sampled on start
- in_valid  in  1  act/wgt beat valid
- in_ready  out  1  high only in ACCUM
- act  in  DATA_W  signed activation
- wgt  in  DATA_W  signed weight
- busy  out  1  high in ACCUM or FINAL
- out_valid  out  1  result valid, held until next start
- out_data  out  DATA_W  signed saturated result
- sat  out  1  result was clipped to -128 or 127, valid with out_valid

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, acc=0, cnt=0, out_valid=0, out_data=0, sat=0, in_ready=0, busy=0. Reset takes effect mid-operation with no partial output.
- ena low: no register changes. A beat is accepted only when in_valid & in_ready & ena. start is ignored while ena is low.
- States: IDLE, ACCUM, FINAL, DONE.
- start in any state (ena=1):
  - Latches vec_len, shift and relu_en.
  - Sets acc = sign-extended bias, cnt=0, out_valid=0, sat=0.
  - Next state is ACCUM, or FINAL if vec_len==0.
  - start during ACCUM aborts the current vector and restarts.
  - start takes priority over a beat presented in the same cycle; that beat is dropped.
- ACCUM: each accepted beat does acc += sext(act*wgt), a 16-bit signed product, and cnt++. The beat accepted with cnt==len-1 moves the state to FINAL. vec_len > MAX_LEN is clamped to MAX_LEN.
- FINAL (one cycle), producing r:
  - r = acc >>> shift (arithmetic shift, floor rounding).
  - If relu_en and r<0, r=0.
  - Saturate r to [-128,127]; sat=1 if clipped.
  - Register out_data and sat, set out_valid=1, go to DONE.
- DONE: out_data, sat and out_valid held stable. in_ready=0, busy=0. Leaves only on start or reset.
- Latency: with the last beat accepted at edge k, out_valid rises after edge k+1 (2 cycles from the last beat's in_valid cycle). For vec_len==0, out_valid rises 2 edges after start.
- in_valid outside ACCUM is ignored.
- The accumulator cannot overflow: |sum| ≤ 16·16384+128 < 2^19.

Decomposition:
- Package nn_accel_pkg holds:
  - the state enum (IDLE/ACCUM/FINAL/DONE);
  - DATA_W, ACC_W, MAX_LEN, LEN_W and SHIFT_W constants;
  - the signed 8-bit saturation limits SAT_MAX=127 and SAT_MIN=-128.
- One combinational sub-module, nn_requant_sat: inputs acc, shift, relu_en; outputs out_data, sat. It is reused by future multi-neuron variants.
- FSM, counter and accumulator stay in nn_mac_neuron_pe.

Test Plan:
- Dot product: len=4, bias=0, shift=0, relu=0, act {1,2,3,4}, wgt {5,6,7,8} back-to-back -> out_data=70 (0x46), sat=0, out_valid 2 cycles after the last beat.
- Saturation: len=2, act {100,100}, wgt {100,100}, shift=7 -> 20000>>>7=156 -> out_data=127 (0x7F), sat=1. The same inputs with act {-100,-100} give out_data=-128 (0x80), sat=1.
- ReLU and arithmetic shift: len=1, act=-10, wgt=5, bias=0:
  - relu_en=1 -> out_data=0, sat=0.
  - relu_en=0, shift=2 -> -50>>>2 = -13 (0xF3).
- Bias and len=0: len=0, bias=-7, shift=0 -> out_data=0xF9 two edges after start. In a separate run, len=3 with bias=10 and products {2,2,2} -> out_data=16.
- Stalls: the len=4 vector from the first scenario, with in_valid gaps and ena low for 3 cycles mid-vector (beats presented during ena-low are not counted) -> out_data=70, with the state frozen while ena is low.
- Abort and reset:
  - start mid-ACCUM with new len=1, act=3, wgt=3 -> out_data=9, with no trace of the old vector.
  - rst_n low mid-ACCUM -> all outputs 0 after the next edge, state IDLE, in_ready=0.

Source files
------------

// File: rtl/nn_accel_pkg.sv
// Shared types and constants for the neural-network accelerator datapath.
package nn_accel_pkg;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 20;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int SHIFT_W = 3;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FINAL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/nn_requant_sat.sv
// Requantizes an accumulator: arithmetic right shift, optional ReLU, then
// saturation to the signed output range.
module nn_requant_sat
  import nn_accel_pkg::*;
(
  input  logic signed [ACC_W-1:0]   acc,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      relu_en,
  output logic signed [DATA_W-1:0]  out_data,
  output logic                      sat
);

  localparam logic signed [ACC_W-1:0] LIM_HI = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] LIM_LO = ACC_W'(SAT_MIN);

  logic signed [ACC_W-1:0] w_shifted;
  logic signed [ACC_W-1:0] w_r;

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    w_shifted = acc >>> shift;
    w_r       = w_shifted;
    if (relu_en && w_shifted[ACC_W-1]) begin
      w_r = '0;
    end
    out_data = w_r[DATA_W-1:0];
    sat      = 1'b0;
    if (w_r > LIM_HI) begin
      out_data = DATA_W'(SAT_MAX);
      sat      = 1'b1;
    end else if (w_r < LIM_LO) begin
      out_data = DATA_W'(SAT_MIN);
      sat      = 1'b1;
    end
  end

endmodule

// File: rtl/nn_mac_neuron_pe.sv
// Single-neuron MAC processing element: bias + dot product over a stream of
// signed activation/weight pairs, then requantize and hold the result.
module nn_mac_neuron_pe
  import nn_accel_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      start,
  input  logic        [LEN_W-1:0]   vec_len,
  input  logic signed [DATA_W-1:0]  bias,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      relu_en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  act,
  input  logic signed [DATA_W-1:0]  wgt,
  output logic                      busy,
  output logic                      out_valid,
  output logic signed [DATA_W-1:0]  out_data,
  output logic                      sat
);

  state_t                  r_state;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_cnt;
  logic [SHIFT_W-1:0]      r_shift;
  logic                    r_relu;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [DATA_W-1:0] r_out_data;
  logic                    r_sat;
  logic                    r_out_valid;

  logic signed [2*DATA_W-1:0] w_prod;
  logic        [LEN_W-1:0]    w_len_clamped;
  logic signed [DATA_W-1:0]   w_req_data;
  logic                       w_req_sat;

  assign w_prod        = act * wgt;
  assign w_len_clamped = (vec_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : vec_len;

  nn_requant_sat u_requant (
    .acc      (r_acc),
    .shift    (r_shift),
    .relu_en  (r_relu),
    .out_data (w_req_data),
    .sat      (w_req_sat)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (ena) begin
      // start wins over a beat presented in the same cycle
      if (start) begin
        r_len       <= w_len_clamped;
        r_shift     <= shift;
        r_relu      <= relu_en;
        r_acc       <= ACC_W'(bias);
        r_cnt       <= '0;
        r_sat       <= 1'b0;
        r_out_valid <= 1'b0;
        r_state     <= (w_len_clamped == '0) ? ST_FINAL : ST_ACCUM;
      end else begin
        case (r_state)
          ST_ACCUM: begin
            if (in_valid) begin
              r_acc <= r_acc + ACC_W'(w_prod);
              r_cnt <= r_cnt + LEN_W'(1);
              if (r_cnt == r_len - LEN_W'(1)) begin
                r_state <= ST_FINAL;
              end
            end
          end
          ST_FINAL: begin
            r_out_data  <= w_req_data;
            r_sat       <= w_req_sat;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = (r_state == ST_ACCUM);
  assign busy      = (r_state == ST_ACCUM) || (r_state == ST_FINAL);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sat       = r_sat;

endmodule

// File: tb/tb_nn_mac_neuron_pe.sv
// Directed bench for nn_mac_neuron_pe: a vector table plus hand-written
// sequences for stalls, clamping, abort and reset.
module tb_nn_mac_neuron_pe;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              start;
  logic [4:0]        vec_len;
  logic signed [7:0] bias;
  logic [2:0]        shift;
  logic              relu_en;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] act;
  logic signed [7:0] wgt;
  logic              busy;
  logic              out_valid;
  logic signed [7:0] out_data;
  logic              sat;

  int errors = 0;
  int checks = 0;

  nn_mac_neuron_pe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .vec_len   (vec_len),
    .bias      (bias),
    .shift     (shift),
    .relu_en   (relu_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act       (act),
    .wgt       (wgt),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]      len;
    logic [7:0]      bias;
    logic [2:0]      shift;
    logic            relu;
    logic [3:0][7:0] act;
    logic [3:0][7:0] wgt;
    logic [7:0]      exp_data;
    logic            exp_sat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input int b, input int sh, input logic relu);
    start   = 1'b1;
    vec_len = 5'(len);
    bias    = 8'(b);
    shift   = 3'(sh);
    relu_en = relu;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int a, input int w);
    in_valid = 1'b1;
    act      = 8'(a);
    wgt      = 8'(w);
    tick();
    in_valid = 1'b0;
  endtask

  // Waits for out_valid with a cycle budget; returns edges waited, -1 on timeout.
  task automatic wait_valid(input int budget, output int edges);
    edges = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        edges = i;
        break;
      end
    end
    if (edges < 0) begin
      errors++;
      checks++;
      $display("FAIL wait_valid: out_valid not seen within %0d cycles", budget);
    end
  endtask

  function automatic vec_t mk(input int len, input int b, input int sh, input logic relu,
                              input int a0, input int a1, input int a2, input int a3,
                              input int w0, input int w1, input int w2, input int w3,
                              input int ed, input logic es);
    vec_t v;
    v.len      = 5'(len);
    v.bias     = 8'(b);
    v.shift    = 3'(sh);
    v.relu     = relu;
    v.act[0]   = 8'(a0);
    v.act[1]   = 8'(a1);
    v.act[2]   = 8'(a2);
    v.act[3]   = 8'(a3);
    v.wgt[0]   = 8'(w0);
    v.wgt[1]   = 8'(w1);
    v.wgt[2]   = 8'(w2);
    v.wgt[3]   = 8'(w3);
    v.exp_data = 8'(ed);
    v.exp_sat  = es;
    return v;
  endfunction

  initial begin
    int edges;

    vecs[0] = mk(4,    0, 0, 1'b0,    1,    2, 3, 4,    5,    6, 7, 8, 8'h46, 1'b0);
    vecs[1] = mk(2,    0, 7, 1'b0,  100,  100, 0, 0,  100,  100, 0, 0, 8'h7F, 1'b1);
    vecs[2] = mk(2,    0, 7, 1'b0, -100, -100, 0, 0,  100,  100, 0, 0, 8'h80, 1'b1);
    vecs[3] = mk(1,    0, 0, 1'b1,  -10,    0, 0, 0,    5,    0, 0, 0, 8'h00, 1'b0);
    vecs[4] = mk(1,    0, 2, 1'b0,  -10,    0, 0, 0,    5,    0, 0, 0, 8'hF3, 1'b0);
    vecs[5] = mk(0,   -7, 0, 1'b0,    0,    0, 0, 0,    0,    0, 0, 0, 8'hF9, 1'b0);
    vecs[6] = mk(3,   10, 0, 1'b0,    1,    1, 2, 0,    2,    2, 1, 0, 8'h10, 1'b0);
    vecs[7] = mk(1, -128, 7, 1'b0, -128,    0, 0, 0, -128,    0, 0, 0, 8'h7F, 1'b0);
    vecs[8] = mk(1,    0, 7, 1'b0,  127,    0, 0, 0, -128,    0, 0, 0, 8'h81, 1'b0);

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; vec_len = '0; bias = '0;
    shift = '0; relu_en = 1'b0; in_valid = 1'b0; act = '0; wgt = '0;
    tick();
    tick();
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data",  {24'd0, out_data}, 32'd0);
    check("reset sat",       32'(sat), 32'd0);
    check("reset in_ready",  32'(in_ready), 32'd0);
    check("reset busy",      32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int n = 0; n < 9; n++) begin
      do_start(int'(vecs[n].len), int'($signed(vecs[n].bias)), int'(vecs[n].shift), vecs[n].relu);
      check($sformatf("v%0d valid cleared", n), 32'(out_valid), 32'd0);
      check($sformatf("v%0d in_ready", n), 32'(in_ready), 32'(vecs[n].len != 0));
      for (int i = 0; i < int'(vecs[n].len); i++) begin
        beat(int'($signed(vecs[n].act[i])), int'($signed(vecs[n].wgt[i])));
      end
      check($sformatf("v%0d final busy", n), 32'(busy), 32'd1);
      check($sformatf("v%0d final not valid", n), 32'(out_valid), 32'd0);
      tick();
      check($sformatf("v%0d valid", n), 32'(out_valid), 32'd1);
      check($sformatf("v%0d data", n), {24'd0, out_data}, {24'd0, vecs[n].exp_data});
      check($sformatf("v%0d sat", n), 32'(sat), 32'(vecs[n].exp_sat));
      check($sformatf("v%0d done busy", n), 32'(busy), 32'd0);
    end

    // DONE holds and ignores stray beats
    beat(50, 50);
    tick();
    check("done hold valid", 32'(out_valid), 32'd1);
    check("done hold data",  {24'd0, out_data}, 32'h81);

    // Stalls: in_valid gaps and ena low for 3 cycles with junk beats and a start
    do_start(4, 0, 0, 1'b0);
    beat(1, 5);
    tick();
    beat(2, 6);
    ena = 1'b0; in_valid = 1'b1; act = 8'sd9; wgt = 8'sd9;
    start = 1'b1; vec_len = 5'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'd1);
      check($sformatf("stall%0d valid", i), 32'(out_valid), 32'd0);
    end
    start = 1'b0; ena = 1'b1; in_valid = 1'b0;
    beat(3, 7);
    tick();
    beat(4, 8);
    wait_valid(5, edges);
    check("stall latency", 32'(edges), 32'd1);
    check("stall data", {24'd0, out_data}, 32'h46);
    check("stall sat",  32'(sat), 32'd0);

    // Length above MAX_LEN is clamped to 16
    do_start(20, 0, 0, 1'b0);
    for (int i = 0; i < 16; i++) beat(1, 1);
    check("clamp in_ready", 32'(in_ready), 32'd0);
    check("clamp busy",     32'(busy), 32'd1);
    tick();
    check("clamp valid", 32'(out_valid), 32'd1);
    check("clamp data",  {24'd0, out_data}, 32'h10);

    // Abort mid-ACCUM; the beat presented with start is dropped
    do_start(4, 0, 0, 1'b0);
    beat(11, 11);
    beat(12, 12);
    in_valid = 1'b1; act = 8'sd50; wgt = 8'sd50;
    do_start(1, 0, 0, 1'b0);
    in_valid = 1'b0;
    check("abort in_ready", 32'(in_ready), 32'd1);
    beat(3, 3);
    tick();
    check("abort valid", 32'(out_valid), 32'd1);
    check("abort data",  {24'd0, out_data}, 32'h09);

    // Reset mid-ACCUM clears everything, including the held result
    do_start(4, 0, 0, 1'b0);
    beat(1, 1);
    beat(1, 1);
    rst_n = 1'b0;
    tick();
    check("mid rst out_data", {24'd0, out_data}, 32'd0);
    check("mid rst valid",    32'(out_valid), 32'd0);
    check("mid rst in_ready", 32'(in_ready), 32'd0);
    check("mid rst busy",     32'(busy), 32'd0);
    rst_n = 1'b1;
    beat(1, 1);
    check("post rst idle", 32'(in_ready), 32'd0);
    check("post rst valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
